// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier issue scheduler.
package mult_sched_pkg;

  localparam int XLEN        = 32;
  localparam int MULT_STAGES = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [4:0]      dest_reg_idx;
    logic            halt;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] dest_value;
    logic [4:0]      dest_reg_idx;
    logic            halt;
  } FU_COMPLETE_PACKET;

  // Index width for a round-robin pointer; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_sched_rbuf.sv
// Result FIFO between the multiplier and the complete stage.
// Push and pop may coincide at any occupancy; a pop while empty is ignored.
module mult_rbuf
  import mult_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  FU_COMPLETE_PACKET       push_data,
  input  logic                    pop,
  output FU_COMPLETE_PACKET       head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  FU_COMPLETE_PACKET mem [DEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic              do_pop;
  logic              full;

  assign do_pop = pop && (count != '0);
  assign full   = (count == CNT_W'(DEPTH));

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + PTR_W'(1);
      end
      if (do_pop) head_ptr <= head_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry, valid forced high when occupied, all-zero when empty.
  always_comb begin
    head = '0;
    if (count != '0) begin
      head       = mem[head_ptr];
      head.valid = 1'b1;
    end
  end

  // The issue credit scheme should make a write into a full buffer impossible.
  assert property (@(posedge clock) disable iff (!reset) !(push && full));

endmodule

// File: rtl/mult_sched.sv
// Round-robin issue scheduler in front of a non-stallable pipelined multiplier.
// Issue is throttled so every op in flight is guaranteed a result-buffer slot.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RBUF_DEPTH = 4,
  parameter int LAT        = MULT_STAGES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic              [NUM_REQ-1:0]   req_valid,
  input  ISSUE_FU_PACKET    [NUM_REQ-1:0]   req_packet,
  output logic              [NUM_REQ-1:0]   req_grant,
  output logic                              mult_start,
  output ISSUE_FU_PACKET                    mult_packet,
  input  logic                              mult_done,
  input  FU_COMPLETE_PACKET                 mult_result,
  input  logic                              complete_stall,
  output logic                              want_to_complete,
  output FU_COMPLETE_PACKET                 fu_packet_out
);

  localparam int RR_W  = ptr_width(NUM_REQ);
  localparam int CNT_W = $clog2(RBUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(RBUF_DEPTH);

  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  grant_idx;
  logic             grant_any;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] rbuf_count;
  logic [CNT_W:0]   occupancy;
  logic             credit_ok;
  logic             push;
  logic             pop;
  int               arb_idx;

  // Slots already promised: buffered results plus ops still in the multiplier.
  assign occupancy = {1'b0, rbuf_count} + {1'b0, inflight};
  assign credit_ok = (occupancy < DEPTH_L);

  // A done with nothing in flight is a leftover from before a reset; drop it.
  assign push = mult_done && (inflight != '0);
  assign pop  = want_to_complete && !complete_stall;

  // Round-robin pick starting at rr_ptr, only when a buffer slot is free.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    if (reset && credit_ok) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        arb_idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (!grant_any && req_valid[arb_idx]) begin
          grant_any = 1'b1;
          grant_idx = RR_W'(arb_idx);
        end
      end
    end
  end

  // Issue outputs derived from the single winner.
  always_comb begin
    req_grant   = '0;
    mult_packet = '0;
    if (grant_any) begin
      req_grant[grant_idx] = 1'b1;
      mult_packet          = req_packet[grant_idx];
    end
  end

  assign mult_start = grant_any;

  // Pointer advances past the winner; in-flight count tracks issue minus done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (grant_any)
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + RR_W'(1);
      case ({mult_start, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  mult_rbuf #(
    .DEPTH (RBUF_DEPTH)
  ) u_rbuf (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (mult_result),
    .pop       (pop),
    .head      (fu_packet_out),
    .count     (rbuf_count)
  );

  assign want_to_complete = (rbuf_count != '0);

  // At most one issue per cycle, each retiring LAT cycles later.
  assert property (@(posedge clock) disable iff (!reset) int'(inflight) <= LAT);

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: external multiplier model, queue-based reference model,
// directed scenarios plus randomized traffic with mid-run resets.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int NUM_REQ    = 2;
  localparam int RBUF_DEPTH = 4;
  localparam int LAT        = MULT_STAGES;

  logic                           clock;
  logic                           reset;
  logic           [NUM_REQ-1:0]   req_valid;
  ISSUE_FU_PACKET [NUM_REQ-1:0]   req_packet;
  logic           [NUM_REQ-1:0]   req_grant;
  logic                           mult_start;
  ISSUE_FU_PACKET                 mult_packet;
  logic                           mult_done;
  FU_COMPLETE_PACKET              mult_result;
  logic                           complete_stall;
  logic                           want_to_complete;
  FU_COMPLETE_PACKET              fu_packet_out;

  mult_sched #(
    .NUM_REQ    (NUM_REQ),
    .RBUF_DEPTH (RBUF_DEPTH),
    .LAT        (LAT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_packet       (req_packet),
    .req_grant        (req_grant),
    .mult_start       (mult_start),
    .mult_packet      (mult_packet),
    .mult_done        (mult_done),
    .mult_result      (mult_result),
    .complete_stall   (complete_stall),
    .want_to_complete (want_to_complete),
    .fu_packet_out    (fu_packet_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic FU_COMPLETE_PACKET result_of(input ISSUE_FU_PACKET p);
    FU_COMPLETE_PACKET r;
    r.valid        = 1'b1;
    r.dest_value   = p.rs1_value * p.rs2_value;
    r.dest_reg_idx = p.dest_reg_idx;
    r.halt         = p.halt;
    return r;
  endfunction

  function automatic ISSUE_FU_PACKET make_pkt(input int a, input int b, input int dst, input bit h);
    ISSUE_FU_PACKET p;
    p.valid        = 1'b1;
    p.rs1_value    = 32'(a);
    p.rs2_value    = 32'(b);
    p.dest_reg_idx = 5'(dst);
    p.halt         = h;
    return p;
  endfunction

  // Multiplier: fixed LAT-cycle pipe, not resettable, never stalls.
  logic              pipe_v [LAT+1];
  FU_COMPLETE_PACKET pipe_d [LAT+1];
  initial begin
    for (int k = 0; k <= LAT; k++) begin
      pipe_v[k] = 1'b0;
      pipe_d[k] = '0;
    end
    mult_done   = 1'b0;
    mult_result = '0;
  end
  always @(negedge clock) begin
    for (int k = LAT; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_d[k] = pipe_d[k-1];
    end
    pipe_v[0]   = mult_start;
    pipe_d[0]   = result_of(mult_packet);
    mult_done   = pipe_v[LAT];
    mult_result = pipe_d[LAT];
  end

  // Reference model: every issued op is an entry in program order, visible at
  // the buffer head from issue cycle + LAT + 1 until popped.
  typedef struct {
    FU_COMPLETE_PACKET pkt;
    int                ready;
  } ent_t;
  ent_t exp_q[$];
  int   m_rr = 0;
  int   cyc  = 0;

  function automatic int model_grant();
    if (!reset) return -1;
    if (exp_q.size() >= RBUF_DEPTH) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_rr + i) % NUM_REQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    int g;
    if (!reset) begin
      exp_q.delete();
      m_rr = 0;
    end else begin
      g = model_grant();
      if (exp_q.size() > 0 && exp_q[0].ready <= cyc && !complete_stall)
        exp_q.delete(0);
      if (g >= 0) begin
        exp_q.push_back('{pkt: result_of(req_packet[g]), ready: cyc + LAT + 1});
        m_rr = (g + 1) % NUM_REQ;
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    int                   g;
    logic [NUM_REQ-1:0]   exp_g;
    ISSUE_FU_PACKET       exp_mp;
    FU_COMPLETE_PACKET    exp_out;
    g      = model_grant();
    exp_g  = '0;
    exp_mp = '0;
    if (g >= 0) begin
      exp_g[g] = 1'b1;
      exp_mp   = req_packet[g];
    end
    exp_out = '0;
    if (reset && exp_q.size() > 0 && exp_q[0].ready <= cyc) exp_out = exp_q[0].pkt;
    check("req_grant", 128'(req_grant), 128'(exp_g));
    check("mult_start", 128'(mult_start), 128'(g >= 0));
    check("mult_packet", 128'(mult_packet), 128'(exp_mp));
    check("want_to_complete", 128'(want_to_complete), 128'(exp_out.valid));
    check("fu_packet_out", 128'(fu_packet_out), 128'(exp_out));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    req_valid      = '0;
    req_packet     = '0;
    complete_stall = 1'b0;
  endtask

  // Reset for two cycles, then a quiet period long enough to flush stale dones.
  task automatic do_reset();
    reset = 1'b0;
    go_idle();
    tick();
    tick();
    reset = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    int ngr;
    reset = 1'b0;
    go_idle();
    tick();
    tick();
    #2;
    check("reset_wtc", 128'(want_to_complete), 128'(0));
    check("reset_out", 128'(fu_packet_out), 128'(0));
    check("reset_grant", 128'(req_grant), 128'(0));
    tick();
    reset = 1'b1;
    tick();

    // Single 3*5 op: granted immediately, result at head LAT+1 cycles later.
    req_valid     = 2'b01;
    req_packet[0] = make_pkt(3, 5, 9, 1'b0);
    #2;
    check("single_grant", 128'(req_grant), 128'(2'b01));
    tick();
    go_idle();
    repeat (LAT - 1) tick();
    #2;
    check("single_early_wtc", 128'(want_to_complete), 128'(0));
    tick();
    #2;
    check("single_wtc", 128'(want_to_complete), 128'(1));
    check("single_value", 128'(fu_packet_out.dest_value), 128'(15));
    check("single_dest", 128'(fu_packet_out.dest_reg_idx), 128'(9));
    repeat (LAT + 4) tick();

    // Both requesters valid: grants alternate from requester 0.
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_packet[0] = make_pkt(i + 1, 2, 1, 1'b0);
      req_packet[1] = make_pkt(i + 1, 3, 2, 1'b1);
      #2;
      check("rr_grant", 128'(req_grant), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
      tick();
    end
    go_idle();
    repeat (LAT + 8) tick();

    // Stalled completion: exactly RBUF_DEPTH grants, then one per pop.
    do_reset();
    complete_stall = 1'b1;
    req_valid      = 2'b01;
    ngr            = 0;
    for (int i = 0; i < 12; i++) begin
      req_packet[0] = make_pkt(i + 2, 3, 4, 1'b0);
      #2;
      if (req_grant[0]) ngr++;
      tick();
    end
    check("stall_grant_count", 128'(ngr), 128'(4));
    complete_stall = 1'b0;
    req_packet[0]  = make_pkt(20, 1, 5, 1'b0);
    #2;
    check("stall_release_no_grant", 128'(req_grant), 128'(0));
    check("stall_head0", 128'(fu_packet_out.dest_value), 128'(6));
    tick();
    #2;
    check("stall_release_grant", 128'(req_grant), 128'(2'b01));
    check("stall_head1", 128'(fu_packet_out.dest_value), 128'(9));
    tick();
    go_idle();
    repeat (LAT + 8) tick();

    // Reset with results buffered and in flight.
    do_reset();
    complete_stall = 1'b1;
    req_valid      = 2'b01;
    for (int i = 0; i < 4; i++) begin
      req_packet[0] = make_pkt(7, i + 1, 3, 1'b1);
      tick();
    end
    tick();
    tick();
    #2;
    check("prereset_wtc", 128'(want_to_complete), 128'(1));
    reset = 1'b0;
    #1;
    check("async_grant", 128'(req_grant), 128'(0));
    check("async_start", 128'(mult_start), 128'(0));
    check("async_wtc", 128'(want_to_complete), 128'(0));
    check("async_out", 128'(fu_packet_out), 128'(0));
    tick();
    tick();
    reset = 1'b1;
    go_idle();
    for (int i = 0; i < LAT + 3; i++) begin
      #2;
      check("post_reset_wtc", 128'(want_to_complete), 128'(0));
      tick();
    end

    // Randomized traffic, with resets landing mid-operation.
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 700; c++) begin
        req_valid = NUM_REQ'($urandom);
        for (int r = 0; r < NUM_REQ; r++) begin
          if ($urandom_range(0, 3) == 0)
            req_packet[r] = make_pkt(int'($urandom), int'($urandom), int'($urandom_range(0, 31)),
                                     $urandom_range(0, 15) == 0);
          else
            req_packet[r] = make_pkt(int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)),
                                     int'($urandom_range(0, 31)), $urandom_range(0, 15) == 0);
          req_packet[r].valid = 1'($urandom);
        end
        complete_stall = ($urandom_range(0, 99) < 20 + 15 * seg);
        tick();
      end
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
